// File: rtl/lsu_mem_port.sv
// ============================================================================
// Module   : lsu_mem_port
// Brief    : RV64I load/store initiator for a 64-bit little-endian data memory.
//            Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_port #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [7:0]        mem_w_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  input  logic [63:0]       mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_wdata;
  logic [63:0]         r_rdata;
  logic                r_err;

  logic                w_legal;
  logic                w_ok;
  logic [7:0]          w_size_mask;
  logic [63:0]         w_load_data;
  logic                w_unused_addr;

  // Only the low ADDR_W address bits reach the memory.
  assign w_unused_addr = ^req_addr[63:ADDR_W];

  assign w_legal = r_we ? ~r_funct3[2] : (r_funct3 != 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (r_funct3[1:0])
      2'd1:    w_misalign = r_addr[0];
      2'd2:    w_misalign = |r_addr[1:0];
      2'd3:    w_misalign = |r_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end
  assign w_ok = w_legal & ~w_misalign;
`else
  assign w_ok = w_legal;
`endif

  always_comb begin
    w_size_mask = 8'h00;
    case (r_funct3[1:0])
      2'd0:    w_size_mask = 8'h01;
      2'd1:    w_size_mask = 8'h03;
      2'd2:    w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  always_comb begin
    w_load_data = 64'd0;
    case (r_funct3)
      3'b000:  w_load_data = {{56{mem_read_data[7]}},  mem_read_data[7:0]};
      3'b001:  w_load_data = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  w_load_data = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b011:  w_load_data = mem_read_data;
      3'b100:  w_load_data = {56'd0, mem_read_data[7:0]};
      3'b101:  w_load_data = {48'd0, mem_read_data[15:0]};
      3'b110:  w_load_data = {32'd0, mem_read_data[31:0]};
      default: w_load_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Mask is decoded from state so an async reset kills a pending write at once.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_w_mask  = 8'h00;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_we && w_ok) begin
          mem_w_mask = w_size_mask;
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 64'd0;
      r_rdata  <= 64'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_W-1:0];
        r_wdata  <= req_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= (!r_we && w_ok) ? w_load_data : 64'd0;
        r_err   <= ~w_ok;
      end
    end
  end

  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
// Module   : tb_lsu_mem_port
// Brief    : Self-checking bench for lsu_mem_port with a byte-array memory and
//            a shadow-memory reference model (honours LSU_MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_port;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [63:0]       req_addr = 64'd0;
  logic [63:0]       req_wdata = 64'd0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [7:0]        mem_w_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_write_data;
  logic [63:0]       mem_read_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem    [0:65535];
  logic [7:0] shadow [0:65535];
  logic       mem_clear = 1'b0;

  lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_w_mask     (mem_w_mask),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, byte-masked write on the clock edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++)
        if (mem_w_mask[i]) mem[16'(mem_address + 16'(i))] <= mem_write_data[8*i +: 8];
    end
  end

  always_comb begin
    mem_read_data = 64'd0;
    for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = mem[16'(mem_address + 16'(i))];
  end

  // Reference model: applies one request to the shadow memory and returns the expected response.
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, output logic [63:0] erd,
                       output logic eerr, output logic [7:0] emask);
    int nbytes;
    bit ok;
    logic [63:0] raw;
    logic signed [63:0] s;
    logic [15:0] a;
    nbytes = 1 << f3[1:0];
    ok = we ? (f3[2] == 1'b0) : (f3 != 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(addr[2:0]) % nbytes) != 0) ok = 1'b0;
`endif
    a = addr[15:0];
    erd = 64'd0;
    emask = 8'h00;
    eerr = !ok;
    if (ok && we) begin
      emask = 8'((1 << nbytes) - 1);
      for (int i = 0; i < nbytes; i++) shadow[16'(a + 16'(i))] = wdata[8*i +: 8];
    end else if (ok) begin
      raw = 64'd0;
      for (int i = 0; i < nbytes; i++) raw[8*i +: 8] = shadow[16'(a + 16'(i))];
      if (f3[2]) begin
        erd = raw;
      end else begin
        s = raw << (64 - 8*nbytes);
        erd = s >>> (64 - 8*nbytes);
      end
    end
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wdata, output logic [63:0] rd, output logic er,
                      output int lat, output logic [7:0] mseen, output int mcnt);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; mcnt = 0; mseen = 8'h00;
    while (!resp_valid && lat < 8) begin
      if (mem_w_mask != 8'h00) begin mcnt++; mseen = mem_w_mask; end
      lat++;
      @(negedge clk);
    end
    if (mem_w_mask != 8'h00) mcnt++;
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    checks++; if (mem_w_mask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h exp=00", mem_w_mask); end
    checks++; if (mem_address !== 16'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    checks++; if (mem_write_data !== 64'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_write_data); end
    mem_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_clear = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got ready=%b valid=%b exp ready=1 valid=0", req_ready, resp_valid);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd;
    logic        err;
    logic [7:0]  mask;
  } op_t;

  task automatic test_directed();
    op_t ops [14];
    logic [63:0] rd, erd; logic er, eer; logic [7:0] ms, em; int lat, mc;
    ops[0]  = '{1'b1, 3'd3, 64'h0100, 64'h8877665544332211, 64'd0, 1'b0, 8'hFF};
    ops[1]  = '{1'b0, 3'd3, 64'h0100, 64'd0, 64'h8877665544332211, 1'b0, 8'h00};
    ops[2]  = '{1'b1, 3'd0, 64'h0200, 64'h123456789ABCDEFF, 64'd0, 1'b0, 8'h01};
    ops[3]  = '{1'b0, 3'd0, 64'h0200, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 8'h00};
    ops[4]  = '{1'b0, 3'd4, 64'h0200, 64'd0, 64'h00000000000000FF, 1'b0, 8'h00};
    ops[5]  = '{1'b1, 3'd2, 64'h0300, 64'h0000000080000000, 64'd0, 1'b0, 8'h0F};
    ops[6]  = '{1'b0, 3'd2, 64'h0300, 64'd0, 64'hFFFFFFFF80000000, 1'b0, 8'h00};
    ops[7]  = '{1'b0, 3'd6, 64'h0300, 64'd0, 64'h0000000080000000, 1'b0, 8'h00};
    ops[8]  = '{1'b0, 3'd1, 64'h0302, 64'd0, 64'hFFFFFFFFFFFF8000, 1'b0, 8'h00};
    ops[9]  = '{1'b1, 3'd4, 64'h0400, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b1, 8'h00};
    ops[10] = '{1'b0, 3'd3, 64'h0400, 64'd0, 64'd0, 1'b0, 8'h00};
    ops[11] = '{1'b0, 3'd7, 64'h0100, 64'd0, 64'd0, 1'b1, 8'h00};
`ifdef LSU_MISALIGN_TRAP_EN
    ops[12] = '{1'b1, 3'd2, 64'h0502, 64'h00000000AABBCCDD, 64'd0, 1'b1, 8'h00};
    ops[13] = '{1'b0, 3'd3, 64'h0500, 64'd0, 64'd0, 1'b0, 8'h00};
`else
    ops[12] = '{1'b1, 3'd2, 64'h0502, 64'h00000000AABBCCDD, 64'd0, 1'b0, 8'h0F};
    ops[13] = '{1'b0, 3'd3, 64'h0500, 64'd0, 64'h0000AABBCCDD0000, 1'b0, 8'h00};
`endif
    for (int k = 0; k < 14; k++) begin
      model(ops[k].we, ops[k].f3, ops[k].addr, ops[k].wdata, erd, eer, em);
      xact(ops[k].we, ops[k].f3, ops[k].addr, ops[k].wdata, rd, er, lat, ms, mc);
      checks++; if (rd !== ops[k].rd) begin failures++; $display("FAIL dir%0d_rdata got=%h exp=%h", k, rd, ops[k].rd); end
      checks++; if (er !== ops[k].err) begin failures++; $display("FAIL dir%0d_err got=%b exp=%b", k, er, ops[k].err); end
      checks++; if (ms !== ops[k].mask || mc !== ((ops[k].mask != 8'h00) ? 1 : 0)) begin
        failures++; $display("FAIL dir%0d_mask got=%h cycles=%0d exp=%h", k, ms, mc, ops[k].mask);
      end
      checks++; if (lat !== 1) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=1", k, lat); end
    end
  endtask

  task automatic test_hold();
    logic [63:0] erd; logic eer; logic [7:0] em;
    model(1'b0, 3'd3, 64'h0100, 64'd0, erd, eer, em);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd3; req_addr = 64'h0100; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== erd) begin
      failures++; $display("FAIL hold_first got valid=%b rdata=%h exp valid=1 rdata=%h", resp_valid, resp_rdata, erd);
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd3; req_addr = 64'h1000; req_wdata = 64'hFFFFFFFFFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== erd || req_ready !== 1'b0 || mem_w_mask !== 8'h00) begin
        failures++;
        $display("FAIL hold_cycle%0d got valid=%b rdata=%h ready=%b mask=%h exp valid=1 rdata=%h ready=0 mask=00",
                 c, resp_valid, resp_rdata, req_ready, mem_w_mask, erd);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end
    checks++; if (mem[16'h1000] !== shadow[16'h1000]) begin
      failures++; $display("FAIL hold_ignored_req got=%h exp=%h", mem[16'h1000], shadow[16'h1000]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] erd; logic eer; logic [7:0] em;
    int n_ready, n_resp;
    model(1'b0, 3'd3, 64'h0100, 64'd0, erd, eer, em);
    n_ready = 0; n_resp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd3; req_addr = 64'h0100; resp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (req_ready === 1'b1) n_ready++;
      if (resp_valid === 1'b1) begin
        n_resp++;
        checks++; if (resp_rdata !== erd) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", resp_rdata, erd); end
      end
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    checks++; if (n_ready !== 3 || n_resp !== 3) begin
      failures++; $display("FAIL b2b_rate got accepts=%0d resps=%0d exp 3/3 in 9 cycles", n_ready, n_resp);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, erd, addr, wd; logic er, eer, we; logic [2:0] f3; logic [7:0] ms, em;
    int lat, mc, bad;
    for (int k = 0; k < 60; k++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = {32'($urandom), 16'($urandom), 16'h1000 + 16'($urandom_range(0, 31))};
      wd   = {32'($urandom), 32'($urandom)};
      model(we, f3, addr, wd, erd, eer, em);
      xact(we, f3, addr, wd, rd, er, lat, ms, mc);
      checks++; if (rd !== erd || er !== eer) begin
        failures++; $display("FAIL rnd%0d_resp we=%b f3=%0d a=%h got rdata=%h err=%b exp rdata=%h err=%b",
                             k, we, f3, addr[15:0], rd, er, erd, eer);
      end
      checks++; if (ms !== em || mc !== ((em != 8'h00) ? 1 : 0) || lat !== 1) begin
        failures++; $display("FAIL rnd%0d_timing got mask=%h cycles=%0d lat=%0d exp mask=%h lat=1", k, ms, mc, lat, em);
      end
    end
    bad = 0;
    for (int a = 16'h1000; a < 16'h1030; a++) if (mem[a] !== shadow[a]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_memory got %0d differing bytes exp 0", bad); end
  endtask

  task automatic test_reset_in_access();
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd3; req_addr = 64'h0600;
    req_wdata = 64'hA5A5A5A5_5A5A5A5A; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_w_mask !== 8'hFF) begin failures++; $display("FAIL rst_access_mask_pre got=%h exp=FF", mem_w_mask); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_w_mask !== 8'h00) begin failures++; $display("FAIL rst_access_mask got=%h exp=00", mem_w_mask); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_address !== 16'd0 || mem_write_data !== 64'd0) begin
      failures++; $display("FAIL rst_access_outputs got ready=%b valid=%b addr=%h wdata=%h exp 1/0/0/0",
                           req_ready, resp_valid, mem_address, mem_write_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int a = 16'h0600; a < 16'h0608; a++) if (mem[a] !== shadow[a]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_access_memory got %0d written bytes exp 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) shadow[i] = 8'h00;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_in_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
